// File: rtl/game_status_tracker_if.sv
// Entry/verdict bus between the sequence checker, the status tracker and the display.
// master drives the game inputs; slave is the tracker, which returns its counters and flags.
interface game_status_tracker_if;
    logic        start;
    logic        en;
    logic        combo;
    logic        answer;
    logic [2:0]  lives;
    logic [7:0]  streak;
    logic [7:0]  best_streak;
    logic [15:0] score;
    logic [3:0]  mult;
    logic        level_done;
    logic        game_over;
    logic [1:0]  o_state;

    modport master (
        output start, en, combo, answer,
        input  lives, streak, best_streak, score, mult, level_done, game_over, o_state
    );

    modport slave (
        input  start, en, combo, answer,
        output lives, streak, best_streak, score, mult, level_done, game_over, o_state
    );
endinterface

// File: rtl/game_status_tracker.sv
// Game status tracker: lives, streaks and a saturating score driven by per-entry checker verdicts,
// sequenced through IDLE / PLAY / LEVEL_DONE / GAME_OVER.
module game_status_tracker #(
    parameter int INIT_LIVES  = 3,
    parameter int MAX_MULT    = 4,
    parameter int LEVEL_BONUS = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    game_status_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PLAY       = 2'd1,
        S_LEVEL_DONE = 2'd2,
        S_GAME_OVER  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [2:0]  lives_reg;
    logic [7:0]  streak_reg;
    logic [7:0]  best_reg;
    logic [15:0] score_reg;
    logic        level_done_reg;
    logic        game_over_reg;

    logic [6:0]  mult_raw;
    logic [3:0]  mult_val;
    logic [7:0]  streak_next;
    logic [7:0]  best_next;
    logic [16:0] score_sum;
    logic [15:0] score_next;

    // Multiplier follows the streak held before the current entry is counted.
    assign mult_raw = 7'd1 + 7'(streak_reg >> 2);
    assign mult_val = (mult_raw > 7'(MAX_MULT)) ? 4'(MAX_MULT) : mult_raw[3:0];

    assign streak_next = (streak_reg == 8'hFF) ? 8'hFF : streak_reg + 8'd1;
    assign best_next   = (streak_next > best_reg) ? streak_next : best_reg;

    // One extra bit on the sum catches the overflow that saturates the score.
    assign score_sum  = {1'b0, score_reg} + 17'(mult_val)
                      + (bus.answer ? 17'(LEVEL_BONUS) : 17'd0);
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            lives_reg      <= 3'd0;
            streak_reg     <= 8'd0;
            best_reg       <= 8'd0;
            score_reg      <= 16'd0;
            level_done_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_GAME_OVER: begin
                    if (bus.start) begin
                        state_reg      <= S_PLAY;
                        lives_reg      <= 3'(INIT_LIVES);
                        streak_reg     <= 8'd0;
                        best_reg       <= 8'd0;
                        score_reg      <= 16'd0;
                        level_done_reg <= 1'b0;
                        game_over_reg  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (bus.start) begin
                        lives_reg  <= 3'(INIT_LIVES);
                        streak_reg <= 8'd0;
                        best_reg   <= 8'd0;
                        score_reg  <= 16'd0;
                    end else if (bus.en) begin
                        if (bus.combo) begin
                            streak_reg <= streak_next;
                            best_reg   <= best_next;
                            score_reg  <= score_next;
                            if (bus.answer) begin
                                state_reg      <= S_LEVEL_DONE;
                                level_done_reg <= 1'b1;
                            end
                        end else begin
                            streak_reg <= 8'd0;
                            // Losing the last life ends the game; lives never wraps below zero.
                            if (lives_reg <= 3'd1) begin
                                lives_reg     <= 3'd0;
                                state_reg     <= S_GAME_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                lives_reg <= lives_reg - 3'd1;
                            end
                        end
                    end
                end
                S_LEVEL_DONE: begin
                    if (bus.start) begin
                        state_reg      <= S_PLAY;
                        level_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= S_IDLE;
                    level_done_reg <= 1'b0;
                    game_over_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lives       = lives_reg;
    assign bus.streak      = streak_reg;
    assign bus.best_streak = best_reg;
    assign bus.score       = score_reg;
    assign bus.mult        = mult_val;
    assign bus.level_done  = level_done_reg;
    assign bus.game_over   = game_over_reg;
    assign bus.o_state     = state_reg;

endmodule

// File: tb/tb_game_status_tracker.sv
// Scoreboard bench for game_status_tracker: directed game scenarios plus random play,
// checked against an arithmetic reference model of the game rules.
module tb_game_status_tracker;

    localparam int INIT_LIVES  = 3;
    localparam int MAX_MULT    = 4;
    localparam int LEVEL_BONUS = 50;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    game_status_tracker_if bus ();

    game_status_tracker #(
        .INIT_LIVES (INIT_LIVES),
        .MAX_MULT   (MAX_MULT),
        .LEVEL_BONUS(LEVEL_BONUS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lives;
        int streak;
        int best;
        int score;
        int mult;
        int state;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: 0=IDLE 1=PLAY 2=LEVEL_DONE 3=GAME_OVER
    int m_state  = 0;
    int m_lives  = 0;
    int m_streak = 0;
    int m_best   = 0;
    int m_score  = 0;

    function automatic int f_mult(int s);
        int v;
        v = 1 + s / 4;
        return (v > MAX_MULT) ? MAX_MULT : v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_new_game();
        m_state  = 1;
        m_lives  = INIT_LIVES;
        m_streak = 0;
        m_best   = 0;
        m_score  = 0;
    endtask

    task automatic model_step(bit st, bit e, bit co, bit an);
        int m;
        case (m_state)
            0, 3: if (st) model_new_game();
            1: begin
                if (st) model_new_game();
                else if (e) begin
                    if (co) begin
                        m = f_mult(m_streak);
                        m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                        if (m_streak > m_best) m_best = m_streak;
                        m_score = m_score + m + (an ? LEVEL_BONUS : 0);
                        if (m_score > 65535) m_score = 65535;
                        if (an) m_state = 2;
                    end else begin
                        m_streak = 0;
                        m_lives  = m_lives - 1;
                        if (m_lives <= 0) begin
                            m_lives = 0;
                            m_state = 3;
                        end
                    end
                end
            end
            default: if (st) m_state = 1;
        endcase
    endtask

    task automatic drive(bit st, bit e, bit co, bit an);
        exp_t x;
        @(negedge clk);
        bus.start  = st;
        bus.en     = e;
        bus.combo  = co;
        bus.answer = an;
        model_step(st, e, co, an);
        x.lives  = m_lives;
        x.streak = m_streak;
        x.best   = m_best;
        x.score  = m_score;
        x.mult   = f_mult(m_streak);
        x.state  = m_state;
        q.push_back(x);
        $display("txn t=%0t start=%0d en=%0d combo=%0d answer=%0d -> exp state=%0d lives=%0d streak=%0d score=%0d",
                 $time, st, e, co, an, m_state, m_lives, m_streak, m_score);
    endtask

    // Wait until just after the edge that consumed the last driven inputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock edge with a pending expectation is compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                chk("lives",       int'(bus.lives),       e.lives);
                chk("streak",      int'(bus.streak),      e.streak);
                chk("best_streak", int'(bus.best_streak), e.best);
                chk("score",       int'(bus.score),       e.score);
                chk("mult",        int'(bus.mult),        e.mult);
                chk("o_state",     int'(bus.o_state),     e.state);
                chk("level_done",  int'(bus.level_done),  (e.state == 2) ? 1 : 0);
                chk("game_over",   int'(bus.game_over),   (e.state == 3) ? 1 : 0);
            end
        end
    end

    task automatic chk_all_reset(string tag);
        chk({tag, "_lives"},      int'(bus.lives),       0);
        chk({tag, "_streak"},     int'(bus.streak),      0);
        chk({tag, "_best"},       int'(bus.best_streak), 0);
        chk({tag, "_score"},      int'(bus.score),       0);
        chk({tag, "_mult"},       int'(bus.mult),        1);
        chk({tag, "_state"},      int'(bus.o_state),     0);
        chk({tag, "_level_done"}, int'(bus.level_done),  0);
        chk({tag, "_game_over"},  int'(bus.game_over),   0);
    endtask

    initial begin
        int guard;
        bus.start  = 1'b0;
        bus.en     = 1'b0;
        bus.combo  = 1'b0;
        bus.answer = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk_all_reset("por");
        @(negedge clk);
        reset = 1'b0;

        // en in IDLE is ignored
        drive(0, 1, 0, 0);

        // Full level: 16 correct entries, sequence complete on the last
        drive(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, 1, (i == 15));
        settle();
        chk("lvl_score",      int'(bus.score), 90);
        chk("lvl_streak",     int'(bus.streak), 16);
        chk("lvl_best",       int'(bus.best_streak), 16);
        chk("lvl_level_done", int'(bus.level_done), 1);
        chk("lvl_lives",      int'(bus.lives), 3);
        drive(0, 1, 0, 0);  // en ignored in LEVEL_DONE
        drive(1, 0, 0, 0);  // next level keeps counters
        drive(0, 1, 1, 0);

        // Fresh game: 5 correct, 1 wrong, 2 correct
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        settle();
        chk("mix_streak", int'(bus.streak), 2);
        chk("mix_best",   int'(bus.best_streak), 5);
        chk("mix_lives",  int'(bus.lives), 2);
        chk("mix_score",  int'(bus.score), 8);
        chk("mix_mult",   int'(bus.mult), 1);

        // Asynchronous reset in the middle of a game
        #1 reset = 1'b1;
        #1 chk_all_reset("async");
        m_state = 0; m_lives = 0; m_streak = 0; m_best = 0; m_score = 0;
        #1 reset = 1'b0;

        // Three wrong entries end the game
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        settle();
        chk("go_flag",  int'(bus.game_over), 1);
        chk("go_lives", int'(bus.lives), 0);
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 0);
        settle();
        chk("go_frozen_score", int'(bus.score), 1);
        chk("go_frozen_lives", int'(bus.lives), 0);
        drive(1, 0, 0, 0);
        settle();
        chk("go_restart_lives", int'(bus.lives), 3);
        chk("go_restart_score", int'(bus.score), 0);

        // start and a wrong entry together: restart wins
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        settle();
        chk("pri_lives",  int'(bus.lives), 3);
        chk("pri_streak", int'(bus.streak), 0);
        chk("pri_score",  int'(bus.score), 0);

        // Long run of completed levels until the score saturates
        drive(1, 0, 0, 0);
        guard = 0;
        while (guard < 3000) begin
            drive(0, 1, 1, 1);
            if (m_score >= 65535) break;
            drive(1, 0, 0, 0);
            guard++;
        end
        settle();
        chk("sat_score",      int'(bus.score), 65535);
        chk("sat_streak",     int'(bus.streak), 255);
        chk("sat_mult",       int'(bus.mult), MAX_MULT);
        chk("sat_level_done", int'(bus.level_done), 1);

        // Random play
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
        drive(0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_status_tracker.md
Name: game_status_tracker

Overview:
- Sits directly downstream of the level sequence-checker FSM and consumes its per-entry verdicts: combo (1 = entry matched), answer (1 = final bit of sequence matched).
- Keeps lives, current streak, best streak and a saturating score.
- Sequences the game through IDLE / PLAY / LEVEL_DONE / GAME_OVER and raises level_done and game_over flags for the display and top-level controller.

Parameters:
- INIT_LIVES, 3, lives loaded at game start (1..7)
- MAX_MULT, 4, cap on the per-entry score multiplier (1..15)
- LEVEL_BONUS, 50, points added when answer=1 on a correct entry

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin new game (from IDLE/GAME_OVER/PLAY) or next level (from LEVEL_DONE)
- en  input  1  one-cycle entry strobe; the same pulse that advances the checker FSM
- combo  input  1  checker verdict for the current entry, valid when en=1
- answer  input  1  checker sequence-complete flag, valid when en=1
- lives  output  3  remaining lives
- streak  output  8  consecutive correct entries
- best_streak  output  8  maximum streak this game
- score  output  16  accumulated score
- mult  output  4  multiplier applied to the next correct entry
- level_done  output  1  high while in LEVEL_DONE
- game_over  output  1  high while in GAME_OVER
- o_state  output  2  current state (IDLE=0, PLAY=1, LEVEL_DONE=2, GAME_OVER=3)

Behaviour:
- Reset (async, any time, including mid-game): state=IDLE. lives=0, streak=0, best_streak=0, score=0, level_done=0, game_over=0. mult is combinational from streak (reset value 1).
- Registers and flags update on the clk edge where inputs are sampled. Latency is 1 cycle from en to updated outputs.
- mult = min(1 + (streak >> 2), MAX_MULT). It is computed from the pre-increment streak.
- IDLE:
  - en ignored.
  - start -> PLAY; lives=INIT_LIVES, score=0, streak=0, best_streak=0.
- PLAY, priority start > en:
  - start=1: full restart as from IDLE; en ignored that cycle.
  - en=1, combo=1:
    - streak = streak+1, saturating at 255.
    - best_streak = max(best_streak, new streak).
    - score = score + mult + (answer ? LEVEL_BONUS : 0), saturating at 16'hFFFF; the sum is computed 17 bits wide.
    - If answer=1 -> LEVEL_DONE.
  - en=1, combo=0:
    - streak=0, answer ignored.
    - lives = lives-1.
    - If lives was 1 -> GAME_OVER (lives=0).
  - en=0: hold.
- LEVEL_DONE:
  - level_done=1; en ignored.
  - start -> PLAY keeping score, lives, streak and best_streak (next level).
- GAME_OVER:
  - game_over=1; en ignored; all counters frozen.
  - start -> PLAY with a full restart.
- level_done and game_over are registered state decodes. They are never high together.
- lives never underflows; en in GAME_OVER has no effect.

Test Plan:
- Assert reset mid-PLAY with score=37 and lives=2 -> all outputs 0 immediately (asynchronous), o_state=0, mult=1.
- start, then 16 en pulses with combo=1 and answer=1 only on the 16th -> score=90 (4·1+4·2+4·3+4·4+50), streak=16, best_streak=16, level_done=1 one cycle after the 16th en, lives=3.
- From a fresh game, 5 correct entries, 1 wrong, 2 correct -> streak=2, best_streak=5, lives=2, score=8 (1+1+1+1+2 + 1+1), mult=1.
- 3 wrong entries -> lives 3,2,1,0 and game_over=1 after the third en. Further en with combo=1 leaves score and lives unchanged. start -> PLAY, lives=3, score=0.
- start and en(combo=0) in the same cycle during PLAY -> restart wins: lives=3, streak=0, score=0.
- Preload score near max with a long correct streak (force score=16'hFFF0, mult=4), then a correct entry with answer=1 -> score=16'hFFFF (saturated), LEVEL_DONE entered.
